// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flow control for the five-stage core: per-register stall/flush and next-PC select.
// Latency: 0 cycles (Mealy outputs from state + current inputs); only state and counters are registered.
// Backpressure: a data-bus wait holds PC..EX/MEM and bubbles MEM/WB; optional bus timeout under PIPE_HAZARD_CTRL_TIMEOUT_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs1_en_i,
    input  logic       id_rs2_en_i,
    input  logic       id_fence_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_is_load_i,
    input  logic       ex_redirect_i,
    input  logic       mem_req_i,
    input  logic       mem_ack_i,
    input  logic       trap_i,
    output logic [4:0] stall_o,
    output logic [4:0] flush_o,
    output logic [1:0] pc_sel_o,
    output logic       fence_inv_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MWAIT   = 2'd1,
        DRAIN   = 2'd2,
        REFETCH = 2'd3
    } state_t;

    state_t     state_q, state_d, eff_state;
    logic       ret_drain_q, ret_drain_d;   // MWAIT was entered from DRAIN
    logic [1:0] dcnt_q, dcnt_d;             // remaining DRAIN cycles before REFETCH
    logic       timeout;
    logic       load_use;
    logic       mem_wait;
    logic [4:0] stall_c, flush_c;

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    logic [7:0] tcnt_q;

    // Timeout counter: counts consecutive MWAIT cycles, clears whenever MWAIT is left
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= 8'd0;
        end else if (state_q == MWAIT && state_d == MWAIT) begin
            tcnt_q <= tcnt_q + 8'd1;
        end else begin
            tcnt_q <= 8'd0;
        end
    end

    assign timeout = (state_q == MWAIT) && !mem_ack_i && (tcnt_q == 8'(MEM_TIMEOUT));
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^8'(MEM_TIMEOUT);
    assign timeout = 1'b0;
`endif

    assign load_use = ex_is_load_i && (ex_rd_i != 5'd0) &&
                      ((id_rs1_en_i && (id_rs1_i == ex_rd_i)) ||
                       (id_rs2_en_i && (id_rs2_i == ex_rd_i)));

    // State, return-state and drain counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            ret_drain_q <= 1'b0;
            dcnt_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            ret_drain_q <= ret_drain_d;
            dcnt_q      <= dcnt_d;
        end
    end

    // Prioritised event decode: trap/timeout > memory wait > redirect > fence > load-use
    always_comb begin
        stall_c     = 5'b00000;
        flush_c     = 5'b00000;
        pc_sel_o    = 2'b00;
        fence_inv_o = 1'b0;
        err_o       = 1'b0;
        state_d     = state_q;
        ret_drain_d = ret_drain_q;
        dcnt_d      = dcnt_q;

        // An ack in MWAIT resumes the interrupted state in the same cycle
        eff_state = state_q;
        if (state_q == MWAIT && mem_ack_i) begin
            eff_state = ret_drain_q ? DRAIN : RUN;
        end

        mem_wait = (eff_state == MWAIT) ||
                   ((eff_state != REFETCH) && mem_req_i && !mem_ack_i);

        if (trap_i || timeout) begin
            flush_c     = 5'b11110;
            pc_sel_o    = 2'b10;
            err_o       = timeout;
            state_d     = RUN;
            ret_drain_d = 1'b0;
            dcnt_d      = 2'd0;
        end else if (mem_wait) begin
            stall_c = 5'b01111;
            flush_c = 5'b10000;
            state_d = MWAIT;
            if (state_q != MWAIT) begin
                ret_drain_d = (state_q == DRAIN);
            end
        end else begin
            case (eff_state)
                DRAIN: begin
                    if (ex_redirect_i) begin
                        pc_sel_o = 2'b01;
                        flush_c  = 5'b00110;
                        state_d  = RUN;
                        dcnt_d   = 2'd0;
                    end else begin
                        stall_c = 5'b00011;
                        flush_c = 5'b00100;
                        if (dcnt_q == 2'd0) begin
                            state_d = REFETCH;
                        end else begin
                            state_d = DRAIN;
                            dcnt_d  = dcnt_q - 2'd1;
                        end
                    end
                end
                REFETCH: begin
                    flush_c     = 5'b00010;
                    pc_sel_o    = 2'b11;
                    fence_inv_o = 1'b1;
                    state_d     = RUN;
                end
                default: begin
                    state_d = RUN;
                    if (ex_redirect_i) begin
                        pc_sel_o = 2'b01;
                        flush_c  = 5'b00110;
                    end else if (id_fence_i) begin
                        stall_c = 5'b00011;
                        flush_c = 5'b00100;
                        state_d = DRAIN;
                        dcnt_d  = 2'd2;
                    end else if (load_use) begin
                        stall_c = 5'b00011;
                        flush_c = 5'b00100;
                    end
                end
            endcase
        end

        if (rst) begin
            stall_c     = 5'b00000;
            flush_c     = 5'b11111;
            pc_sel_o    = 2'b00;
            fence_inv_o = 1'b0;
            err_o       = 1'b0;
        end
    end

    assign flush_o = flush_c;
    assign stall_o = stall_c & ~flush_c;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios then random stimulus against a behavioural model.
// Latency: outputs checked combinationally each cycle at the falling edge.
// Backpressure: memory waits driven via mem_req/mem_ack; timeout checked when PIPE_HAZARD_CTRL_TIMEOUT_EN is set.
module tb_pipe_hazard_ctrl;

    localparam int TO = 3;

    logic       clk, rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_en, id_rs2_en, id_fence, ex_is_load, ex_redirect;
    logic       mem_req, mem_ack, trap;
    logic [4:0] stall, flush;
    logic [1:0] pc_sel;
    logic       fence_inv, err;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    bit in_wait     = 0;
    int wait_cnt    = 0;
    int drain_left  = -1;   // -1: not draining
    bit refetch_due = 0;

    // last sampled DUT outputs
    logic [4:0] o_stall, o_flush;
    logic [1:0] o_pc;
    logic       o_inv, o_err;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_en_i(id_rs1_en), .id_rs2_en_i(id_rs2_en),
        .id_fence_i(id_fence), .ex_rd_i(ex_rd),
        .ex_is_load_i(ex_is_load), .ex_redirect_i(ex_redirect),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack), .trap_i(trap),
        .stall_o(stall), .flush_o(flush), .pc_sel_o(pc_sel),
        .fence_inv_o(fence_inv), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_rs1_en = 0; id_rs2_en = 0; id_fence = 0; ex_is_load = 0; ex_redirect = 0;
        mem_req = 0; mem_ack = 0; trap = 0;
    endtask

    // One clock: compare DUT outputs with the model, then advance the model
    task automatic step();
        logic [4:0] e_stall, e_flush;
        logic [1:0] e_pc;
        logic       e_inv, e_err;
        bit         waiting, tmo, lu;
        @(negedge clk);
        e_stall = 0; e_flush = 0; e_pc = 0; e_inv = 0; e_err = 0;
        lu = ex_is_load && ex_rd != 0 &&
             ((id_rs1_en && id_rs1 == ex_rd) || (id_rs2_en && id_rs2 == ex_rd));
        waiting = in_wait ? !mem_ack : (!refetch_due && mem_req && !mem_ack);
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
        tmo = in_wait && !mem_ack && (wait_cnt == TO);
`else
        tmo = 0;
`endif
        if (rst) begin
            e_flush = 5'b11111;
            in_wait = 0; wait_cnt = 0; drain_left = -1; refetch_due = 0;
        end else if (trap || tmo) begin
            e_flush = 5'b11110; e_pc = 2'b10; e_err = tmo;
            in_wait = 0; wait_cnt = 0; drain_left = -1; refetch_due = 0;
        end else if (waiting) begin
            e_stall = 5'b01111; e_flush = 5'b10000;
            if (in_wait) wait_cnt++;
            else begin in_wait = 1; wait_cnt = 0; end
        end else begin
            in_wait = 0; wait_cnt = 0;
            if (refetch_due) begin
                e_flush = 5'b00010; e_pc = 2'b11; e_inv = 1; refetch_due = 0;
            end else if (drain_left >= 0) begin
                if (ex_redirect) begin
                    e_pc = 2'b01; e_flush = 5'b00110; drain_left = -1;
                end else begin
                    e_stall = 5'b00011; e_flush = 5'b00100;
                    if (drain_left == 0) begin refetch_due = 1; drain_left = -1; end
                    else drain_left--;
                end
            end else if (ex_redirect) begin
                e_pc = 2'b01; e_flush = 5'b00110;
            end else if (id_fence) begin
                e_stall = 5'b00011; e_flush = 5'b00100; drain_left = 2;
            end else if (lu) begin
                e_stall = 5'b00011; e_flush = 5'b00100;
            end
        end
        o_stall = stall; o_flush = flush; o_pc = pc_sel; o_inv = fence_inv; o_err = err;
        chk("stall", {3'b0, stall}, {3'b0, e_stall});
        chk("flush", {3'b0, flush}, {3'b0, e_flush});
        chk("pc_sel", {6'b0, pc_sel}, {6'b0, e_pc});
        chk("fence_inv", {7'b0, fence_inv}, {7'b0, e_inv});
        chk("err", {7'b0, err}, {7'b0, e_err});
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1;
        step(); step();
        chk("rst_flush", {3'b0, o_flush}, 8'h1f);
        rst = 0;
        step();
        chk("idle_flush", {3'b0, o_flush}, 8'h00);

        // load-use on rs2
        ex_is_load = 1; ex_rd = 5; id_rs2_en = 1; id_rs2 = 5;
        step();
        chk("lu_stall", {3'b0, o_stall}, 8'h03);
        chk("lu_flush", {3'b0, o_flush}, 8'h04);
        clr(); step();
        chk("lu_clear", {3'b0, o_stall}, 8'h00);
        ex_is_load = 1; ex_rd = 0; id_rs2_en = 1; id_rs2 = 0;
        step();
        chk("lu_x0", {3'b0, o_stall}, 8'h00);

        // redirect beats load-use
        ex_rd = 7; id_rs1_en = 1; id_rs1 = 7; ex_redirect = 1;
        step();
        chk("rd_pc", {6'b0, o_pc}, 8'h01);
        chk("rd_flush", {3'b0, o_flush}, 8'h06);
        chk("rd_stall", {3'b0, o_stall}, 8'h00);
        clr();

        // 4-cycle memory wait, then ack
        mem_req = 1;
        repeat (4) begin
            step();
            chk("mw_stall", {3'b0, o_stall}, 8'h0f);
        end
        mem_ack = 1; step();
        chk("mw_ack_stall", {3'b0, o_stall}, 8'h00);
        clr(); step();

        // fence with a 2-cycle memory wait during DRAIN
        id_fence = 1; step(); id_fence = 0;
        step();
        mem_req = 1; step(); step();
        mem_ack = 1; step();
        clr();
        step(); step();
        chk("fence_pc", {6'b0, o_pc}, 8'h03);
        chk("fence_inv", {7'b0, o_inv}, 8'h01);
        step(); step();

        // redirect in the second DRAIN cycle aborts the fence
        id_fence = 1; step(); id_fence = 0;
        step();
        ex_redirect = 1; step(); ex_redirect = 0;
        chk("abort_pc", {6'b0, o_pc}, 8'h01);
        repeat (4) begin
            step();
            chk("abort_noinv", {7'b0, o_inv}, 8'h00);
        end

        // ack withheld: timeout or indefinite stall, then reset mid-wait
        mem_req = 1;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
        repeat (TO + 1) step();
        step();
        chk("to_err", {7'b0, o_err}, 8'h01);
        chk("to_pc", {6'b0, o_pc}, 8'h02);
        chk("to_flush", {3'b0, o_flush}, 8'h1e);
        repeat (2) step();
`else
        repeat (300) step();
        chk("hold_stall", {3'b0, o_stall}, 8'h0f);
`endif
        rst = 1; step();
        chk("rst_wait_flush", {3'b0, o_flush}, 8'h1f);
        rst = 0; clr(); step();
        chk("rst_wait_run", {3'b0, o_stall}, 8'h00);

        // trap together with an ack in MWAIT
        mem_req = 1; step(); step();
        mem_ack = 1; trap = 1; step();
        chk("trap_ack_pc", {6'b0, o_pc}, 8'h02);
        clr(); step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            trap        = ($urandom_range(0, 39) == 0);
            ex_redirect = ($urandom_range(0, 7) == 0);
            id_fence    = ($urandom_range(0, 7) == 0);
            mem_req     = $urandom_range(0, 1);
            mem_ack     = $urandom_range(0, 1);
            ex_is_load  = $urandom_range(0, 1);
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_rs1_en   = $urandom_range(0, 1);
            id_rs2_en   = $urandom_range(0, 1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
